// File: rtl/gate_sweep_ctrl_if.sv
// ============================================================================
// Module   : gate_sweep_ctrl_if
// Brief    : Bundles the sweep request/status signals and the gate operand
//            and result lines.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_sweep_ctrl_if;
    logic        start;
    logic        abort;
    logic        a;
    logic        b;
    logic        w;
    logic        x;
    logic        y;
    logic        z;
    logic        busy;
    logic        done;
    logic [1:0]  vec_idx;
    logic [15:0] table_out;
    logic        table_valid;
    logic        mismatch;

    modport master (
        output start, abort, w, x, y, z,
        input  a, b, busy, done, vec_idx, table_out, table_valid, mismatch
    );

    modport slave (
        input  start, abort, w, x, y, z,
        output a, b, busy, done, vec_idx, table_out, table_valid, mismatch
    );
endinterface

`default_nettype wire

// File: rtl/gate_sweep_ctrl.sv
// ============================================================================
// Module   : gate_sweep_ctrl
// Brief    : Steps a 2-input gate through operands 00,01,10,11, waits
//            SETTLE_CYCLES per vector and captures {w,x,y,z} into a 16-bit
//            truth table. Define GATE_SWEEP_CHECK_EN to compare the captured
//            table against EXPECTED and flag a sticky mismatch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_sweep_ctrl #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] EXPECTED      = 16'hC771
) (
    input  logic               clk,
    input  logic               rst,
    gate_sweep_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    localparam logic [7:0] c_settle_last = 8'(SETTLE_CYCLES - 1);

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_vec_idx, w_vec_idx_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt;
    logic [15:0] r_table, w_table_nxt;
    logic        r_valid, w_valid_nxt;
    logic        r_done, w_done_nxt;
    logic [3:0]  w_nibble;
    logic [3:0]  w_shift;

    assign w_nibble = {bus.w, bus.x, bus.y, bus.z};
    assign w_shift  = {r_vec_idx, 2'b00};

    always_comb begin
        w_state_nxt   = r_state;
        w_vec_idx_nxt = r_vec_idx;
        w_cnt_nxt     = r_cnt;
        w_table_nxt   = r_table;
        w_valid_nxt   = r_valid;
        w_done_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.start && !bus.abort) begin
                    w_state_nxt   = ST_SETTLE;
                    w_vec_idx_nxt = 2'd0;
                    w_cnt_nxt     = 8'd0;
                    w_table_nxt   = 16'd0;
                    w_valid_nxt   = 1'b0;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + 8'd1;
                if (r_cnt == c_settle_last) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                // Table is cleared on start, so OR-ing the nibble in place is enough
                w_table_nxt = r_table | (16'(w_nibble) << w_shift);
                w_cnt_nxt   = 8'd0;
                if (r_vec_idx == 2'd3) begin
                    w_state_nxt   = ST_IDLE;
                    w_vec_idx_nxt = 2'd0;
                    w_done_nxt    = 1'b1;
                    w_valid_nxt   = 1'b1;
                end else begin
                    w_state_nxt   = ST_SETTLE;
                    w_vec_idx_nxt = r_vec_idx + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        // Abort overrides any progress made this cycle, including a capture
        if (bus.abort && (r_state != ST_IDLE)) begin
            w_state_nxt   = ST_IDLE;
            w_vec_idx_nxt = 2'd0;
            w_cnt_nxt     = 8'd0;
            w_table_nxt   = 16'd0;
            w_valid_nxt   = 1'b0;
            w_done_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_vec_idx <= 2'd0;
            r_cnt     <= 8'd0;
            r_table   <= 16'd0;
            r_valid   <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_vec_idx <= w_vec_idx_nxt;
            r_cnt     <= w_cnt_nxt;
            r_table   <= w_table_nxt;
            r_valid   <= w_valid_nxt;
            r_done    <= w_done_nxt;
        end
    end

`ifdef GATE_SWEEP_CHECK_EN
    logic r_mismatch;
    logic w_mismatch_nxt;

    always_comb begin
        w_mismatch_nxt = r_mismatch;
        if ((r_state == ST_IDLE) && bus.start && !bus.abort) begin
            w_mismatch_nxt = 1'b0;
        end else if ((r_state == ST_CAPTURE) && !bus.abort &&
                     (w_nibble != EXPECTED[w_shift +: 4])) begin
            w_mismatch_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mismatch <= 1'b0;
        end else begin
            r_mismatch <= w_mismatch_nxt;
        end
    end

    assign bus.mismatch = r_mismatch;
`else
    logic [15:0] w_unused_expected;
    assign w_unused_expected = EXPECTED;
    assign bus.mismatch      = 1'b0;
`endif

    // vec_idx is the operand register itself, so a/b are glitch-free by construction
    assign bus.a           = r_vec_idx[1];
    assign bus.b           = r_vec_idx[0];
    assign bus.vec_idx     = r_vec_idx;
    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.done        = r_done;
    assign bus.table_out   = r_table;
    assign bus.table_valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_gate_sweep_ctrl.sv
// ============================================================================
// Module   : tb_gate_sweep_ctrl
// Brief    : Scoreboard bench for gate_sweep_ctrl with a behavioural gate model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_sweep_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic z_stuck = 1'b0;
    always #5 clk = ~clk;

`ifdef GATE_SWEEP_CHECK_EN
    localparam logic c_mm_on = 1'b1;
`else
    localparam logic c_mm_on = 1'b0;
`endif

    gate_sweep_ctrl_if ifm ();
    gate_sweep_ctrl_if ifs1 ();
    gate_sweep_ctrl_if ifs255 ();

    assign ifm.w = ifm.a & ifm.b;
    assign ifm.x = ifm.a | ifm.b;
    assign ifm.y = ifm.a ^ ifm.b;
    assign ifm.z = z_stuck ? 1'b0 : ~(ifm.a & ifm.b);
    assign ifs1.w = ifs1.a & ifs1.b;
    assign ifs1.x = ifs1.a | ifs1.b;
    assign ifs1.y = ifs1.a ^ ifs1.b;
    assign ifs1.z = ~(ifs1.a & ifs1.b);
    assign ifs255.w = ifs255.a & ifs255.b;
    assign ifs255.x = ifs255.a | ifs255.b;
    assign ifs255.y = ifs255.a ^ ifs255.b;
    assign ifs255.z = ~(ifs255.a & ifs255.b);

    gate_sweep_ctrl #(.SETTLE_CYCLES(2))   u_dut     (.clk(clk), .rst(rst), .bus(ifm));
    gate_sweep_ctrl #(.SETTLE_CYCLES(1))   u_dut_s1  (.clk(clk), .rst(rst), .bus(ifs1));
    gate_sweep_ctrl #(.SETTLE_CYCLES(255)) u_dut_s255(.clk(clk), .rst(rst), .bus(ifs255));

    typedef struct {
        logic [15:0] tbl;
        logic        mm;
        int          start_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec  = 0;
    int   n_miss = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [15:0] e_tbl, input logic e_mm);
        sb_q.push_back('{tbl: e_tbl, mm: e_mm, start_cyc: cyc + 1});
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb_q.size() != 0) begin
            chk("done_timeout", 32'd0, 32'd1);
            sb_q.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && ifm.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("table_out",   32'(ifm.table_out),   32'(mon_e.tbl));
                chk("table_valid", 32'(ifm.table_valid), 32'd1);
                chk("mismatch",    32'(ifm.mismatch),    32'(mon_e.mm));
                chk("latency",     32'(cyc - mon_e.start_cyc), 32'd12);
            end
        end
    end

    task automatic run_settle(input int which, input int bound, input int lat_exp);
        int  t0;
        int  lat;
        logic seen;
        seen = 1'b0;
        lat  = 0;
        if (which == 1) ifs1.start = 1'b1; else ifs255.start = 1'b1;
        @(negedge clk);
        ifs1.start   = 1'b0;
        ifs255.start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if ((which == 1 && ifs1.done === 1'b1) || (which != 1 && ifs255.done === 1'b1)) begin
                seen = 1'b1;
                lat  = cyc - t0;
                break;
            end
        end
        chk("settle_done_seen", 32'(seen), 32'd1);
        chk("settle_latency", 32'(lat), 32'(lat_exp));
        chk("settle_table", (which == 1) ? 32'(ifs1.table_out) : 32'(ifs255.table_out), 32'h0000C771);
    endtask

    initial begin
        logic found;
        ifm.start = 1'b0;  ifm.abort = 1'b0;
        ifs1.start = 1'b0; ifs1.abort = 1'b0;
        ifs255.start = 1'b0; ifs255.abort = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy",  32'(ifm.busy), 32'd0);
        chk("rst_done",  32'(ifm.done), 32'd0);
        chk("rst_ab",    32'({ifm.a, ifm.b}), 32'd0);
        chk("rst_vec",   32'(ifm.vec_idx), 32'd0);
        chk("rst_table", 32'(ifm.table_out), 32'd0);
        chk("rst_valid", 32'(ifm.table_valid), 32'd0);
        chk("rst_mm",    32'(ifm.mismatch), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Golden sweep with per-cycle operand sequence
        ifm.start = 1'b1;
        push_exp(16'hC771, 1'b0);
        @(negedge clk);
        ifm.start = 1'b0;
        for (int j = 0; j < 12; j++) begin
            chk("sweep_ab",   32'({ifm.a, ifm.b}), 32'(j / 3));
            chk("sweep_busy", 32'(ifm.busy), 32'd1);
            @(negedge clk);
        end
        wait_drain();
        chk("golden_valid_hold", 32'(ifm.table_valid), 32'd1);

        // Fault: z stuck at 0
        z_stuck = 1'b1;
        ifm.start = 1'b1;
        push_exp(16'hC660, c_mm_on);
        @(negedge clk);
        ifm.start = 1'b0;
        wait_drain();
        z_stuck = 1'b0;

        // Abort during vector 2
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        repeat (7) @(negedge clk);
        chk("abort_pre_vec", 32'(ifm.vec_idx), 32'd2);
        ifm.abort = 1'b1;
        @(negedge clk);
        ifm.abort = 1'b0;
        chk("abort_busy",  32'(ifm.busy), 32'd0);
        chk("abort_ab",    32'({ifm.a, ifm.b}), 32'd0);
        chk("abort_vec",   32'(ifm.vec_idx), 32'd0);
        chk("abort_table", 32'(ifm.table_out), 32'd0);
        chk("abort_valid", 32'(ifm.table_valid), 32'd0);
        repeat (20) @(negedge clk);

        // Abort and start together in IDLE: abort wins
        ifm.abort = 1'b1;
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.abort = 1'b0;
        ifm.start = 1'b0;
        chk("abort_start_busy", 32'(ifm.busy), 32'd0);

        // Start held for the whole sweep yields exactly one sweep
        ifm.start = 1'b1;
        push_exp(16'hC771, 1'b0);
        repeat (12) @(negedge clk);
        ifm.start = 1'b0;
        wait_drain();
        repeat (5) @(negedge clk);
        chk("held_start_idle", 32'(ifm.busy), 32'd0);

        // Back-to-back: start pulsed in the done cycle
        ifm.start = 1'b1;
        push_exp(16'hC771, 1'b0);
        @(negedge clk);
        ifm.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (ifm.done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("b2b_first_done", 32'(found), 32'd1);
        ifm.start = 1'b1;
        push_exp(16'hC771, 1'b0);
        @(negedge clk);
        ifm.start = 1'b0;
        chk("b2b_valid_drop", 32'(ifm.table_valid), 32'd0);
        chk("b2b_busy",       32'(ifm.busy), 32'd1);
        wait_drain();

        // Asynchronous reset in the middle of a settle period
        ifm.start = 1'b1;
        @(negedge clk);
        ifm.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rstmid_pre_vec", 32'(ifm.vec_idx), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_ab",    32'({ifm.a, ifm.b}), 32'd0);
        chk("rstmid_busy",  32'(ifm.busy), 32'd0);
        chk("rstmid_vec",   32'(ifm.vec_idx), 32'd0);
        chk("rstmid_valid", 32'(ifm.table_valid), 32'd0);
        chk("rstmid_table", 32'(ifm.table_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Settle boundaries
        run_settle(1, 50, 8);
        run_settle(255, 1100, 1024);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d compares failed", n_miss, n_vec);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
